key_evt_fifo: RTL and testbench

- Buffers new-key events from the key scanner (nkpls one-shot plus 5-bit nkv code) so a slower consumer cannot miss a keystroke.
- The consumer is a display, menu or command decoder.
- Sits directly downstream of key_scan and presents events in arrival order on a valid/ready interface.
- Reports fill level and a sticky overflow flag.

---
 rtl/key_pkg.sv | 19 +
 rtl/key_evt_ram.sv | 41 ++++
 rtl/key_evt_fifo.sv | 115 +++++++++++
 tb/tb_key_evt_fifo.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared key-event types for key_scan, key_evt_fifo and downstream decoders.
// Optional macro KEY_EVT_FIFO_TS_EN adds an 8-bit millisecond timestamp to
// each event record.
package key_pkg;

  localparam int unsigned KEY_W = 5;
  localparam int unsigned TS_W  = 8;

  typedef logic [KEY_W-1:0] key_code_t;
  typedef logic [TS_W-1:0]  key_ts_t;

  typedef struct packed {
    key_code_t code;
`ifdef KEY_EVT_FIFO_TS_EN
    key_ts_t   ts;
`endif
  } key_evt_t;

endpackage

// File: rtl/key_evt_ram.sv
// Event storage for key_evt_fifo: DEPTH x key_evt_t register array,
// synchronous write, asynchronous read.
// Ports:
//   clk, rst : clock, async active-high reset (clears entries so the
//              read port shows zero after reset)
//   we       : write enable
//   waddr    : write address
//   wdata    : event written on the clk edge when we is high
//   raddr    : read address
//   rdata    : event at raddr (combinational)
// Macro KEY_EVT_FIFO_TS_EN widens entries via key_evt_t.
module key_evt_ram
  import key_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  key_evt_t      wdata,
  input  logic [AW-1:0] raddr,
  output key_evt_t      rdata
);

  key_evt_t mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/key_evt_fifo.sv
// Key event FIFO: buffers key_scan new-key events (nkpls + nkv) and presents
// them in arrival order on a show-ahead valid/ready interface, with fill
// level and a sticky overflow flag.
// Ports:
//   clk, rst  : 10 MHz clock, async active-high reset
//   nkpls     : new-key pulse, one event per high cycle
//   nkv       : key code sampled with nkpls
//   kv_valid  : head entry available (kv_count != 0)
//   kv_ready  : consumer accepts head when high with kv_valid
//   kv_data   : head entry key code
//   kv_count  : stored entries, 0..DEPTH
//   ovf       : sticky, set when an event is dropped on full
//   ovf_clr   : clears ovf (an overflow drop in the same cycle wins)
//   pls1k     : 1 kHz tick (KEY_EVT_FIFO_TS_EN only)
//   kv_ts     : head entry timestamp (KEY_EVT_FIFO_TS_EN only)
// Macro KEY_EVT_FIFO_TS_EN enables the timestamp counter and ports.
module key_evt_fifo
  import key_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             nkpls,
  input  logic [KEY_W-1:0] nkv,
  output logic             kv_valid,
  input  logic             kv_ready,
  output logic [KEY_W-1:0] kv_data,
`ifdef KEY_EVT_FIFO_TS_EN
  input  logic             pls1k,
  output logic [TS_W-1:0]  kv_ts,
`endif
  output logic [AW:0]      kv_count,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          ovf_q;
  logic          full;
  logic          rd_en;
  logic          wr_en;
  logic          drop;
  key_evt_t      wr_evt;
  key_evt_t      rd_evt;

  assign full  = (count == FULL_CNT);
  assign rd_en = kv_valid & kv_ready;
  // A read in the same cycle frees a slot, so a full FIFO still accepts.
  assign wr_en = nkpls & (~full | rd_en);
  assign drop  = nkpls & ~wr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

`ifdef KEY_EVT_FIFO_TS_EN
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        ts_cnt <= '0;
    else if (pls1k) ts_cnt <= ts_cnt + 1'b1;
  end
`endif

  always_comb begin
    wr_evt      = '0;
    wr_evt.code = nkv;
`ifdef KEY_EVT_FIFO_TS_EN
    wr_evt.ts   = ts_cnt;
`endif
  end

  key_evt_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_evt),
    .raddr (rd_ptr),
    .rdata (rd_evt)
  );

  assign kv_valid = (count != '0);
  assign kv_count = count;
  assign kv_data  = rd_evt.code;
  assign ovf      = ovf_q;
`ifdef KEY_EVT_FIFO_TS_EN
  assign kv_ts    = rd_evt.ts;
`endif

endmodule

// File: tb/tb_key_evt_fifo.sv
module tb_key_evt_fifo;
  import key_pkg::*;

  localparam int DEPTH = 8;
  localparam int NV    = 14;

  logic       clk = 1'b0;
  logic       rst;
  logic       nkpls;
  logic [4:0] nkv;
  logic       kv_valid;
  logic       kv_ready;
  logic [4:0] kv_data;
  logic [3:0] kv_count;
  logic       ovf;
  logic       ovf_clr;
`ifdef KEY_EVT_FIFO_TS_EN
  logic       pls1k;
  logic [7:0] kv_ts;
  logic       pls_nxt;
  int         m_ts;
`endif

  key_evt_fifo #(
    .DEPTH (8),
    .AW    (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .nkpls    (nkpls),
    .nkv      (nkv),
    .kv_valid (kv_valid),
    .kv_ready (kv_ready),
    .kv_data  (kv_data),
`ifdef KEY_EVT_FIFO_TS_EN
    .pls1k    (pls1k),
    .kv_ts    (kv_ts),
`endif
    .kv_count (kv_count),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #50 clk = ~clk;

  typedef struct {
    logic       n;
    logic [4:0] v;
    logic       r;
    logic       c;
    logic       e_valid;
    logic [4:0] e_data;
    logic [3:0] e_count;
    logic       e_ovf;
  } vec_t;

  vec_t     vecs [NV];
  key_evt_t exp_q [$];
  int       n_cmp = 0;
  int       n_bad = 0;
  int       m_ovf = 0;
  int       last_pop = -1;

  function automatic vec_t mk(int n, int v, int r, int c,
                              int ev, int ed, int ec, int eo);
    vec_t t;
    t.n = 1'(n); t.v = 5'(v); t.r = 1'(r); t.c = 1'(c);
    t.e_valid = 1'(ev); t.e_data = 5'(ed); t.e_count = 4'(ec); t.e_ovf = 1'(eo);
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    check("valid", 32'(kv_valid), 32'(exp_q.size() != 0));
    check("count", 32'(kv_count), exp_q.size());
    check("ovf", 32'(ovf), m_ovf);
    if (exp_q.size() != 0) begin
      check("head_code", 32'(kv_data), 32'(exp_q[0].code));
`ifdef KEY_EVT_FIFO_TS_EN
      check("head_ts", 32'(kv_ts), 32'(exp_q[0].ts));
`endif
    end
  endtask

  // One clock cycle: check state at negedge, drive inputs, advance model.
  task automatic cycle(input int n, input int v, input int r, input int c);
    key_evt_t e;
    int       sz;
    bit       rd;
    bit       wr;
    @(negedge clk);
    check_state();
    nkpls    = 1'(n);
    nkv      = 5'(v);
    kv_ready = 1'(r);
    ovf_clr  = 1'(c);
`ifdef KEY_EVT_FIFO_TS_EN
    pls1k    = pls_nxt;
`endif
    sz = exp_q.size();
    rd = (sz != 0) && (r != 0);
    wr = (n != 0) && ((sz < DEPTH) || rd);
    if (rd) begin
      e = exp_q.pop_front();
      check("pop_code", 32'(kv_data), 32'(e.code));
      last_pop = int'(e.code);
    end
    if (wr) begin
      e = '0;
      e.code = 5'(v);
`ifdef KEY_EVT_FIFO_TS_EN
      e.ts = 8'(m_ts);
`endif
      exp_q.push_back(e);
    end
    if ((n != 0) && !wr) m_ovf = 1;
    else if (c != 0)     m_ovf = 0;
`ifdef KEY_EVT_FIFO_TS_EN
    if (pls_nxt) m_ts = (m_ts + 1) % 256;
`endif
    @(posedge clk);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; nkpls = 1'b0; nkv = '0; kv_ready = 1'b0; ovf_clr = 1'b0;
`ifdef KEY_EVT_FIFO_TS_EN
    pls1k = 1'b0; pls_nxt = 1'b0; m_ts = 0;
`endif
    // Single event, ordering, empty-read and read+write rows.
    vecs[0]  = mk(1, 'h0A, 0, 0, 1, 'h0A, 1, 0);
    vecs[1]  = mk(0, 0,    1, 0, 0, 0,    0, 0);
    vecs[2]  = mk(1, 1,    0, 0, 1, 1,    1, 0);
    vecs[3]  = mk(1, 2,    0, 0, 1, 1,    2, 0);
    vecs[4]  = mk(1, 3,    0, 0, 1, 1,    3, 0);
    vecs[5]  = mk(1, 4,    0, 0, 1, 1,    4, 0);
    vecs[6]  = mk(0, 0,    1, 0, 1, 2,    3, 0);
    vecs[7]  = mk(0, 0,    1, 0, 1, 3,    2, 0);
    vecs[8]  = mk(0, 0,    1, 0, 1, 4,    1, 0);
    vecs[9]  = mk(0, 0,    1, 0, 0, 0,    0, 0);
    vecs[10] = mk(0, 0,    1, 0, 0, 0,    0, 0);
    vecs[11] = mk(1, 'h15, 1, 0, 1, 'h15, 1, 0);
    vecs[12] = mk(1, 'h16, 1, 0, 1, 'h16, 1, 0);
    vecs[13] = mk(0, 0,    1, 0, 0, 0,    0, 0);

    @(posedge clk); #1;
    check("rst_valid", 32'(kv_valid), 0);
    check("rst_count", 32'(kv_count), 0);
    check("rst_data",  32'(kv_data),  0);
    check("rst_ovf",   32'(ovf),      0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      nkpls = vecs[i].n; nkv = vecs[i].v; kv_ready = vecs[i].r; ovf_clr = vecs[i].c;
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", i), 32'(kv_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_count", i), 32'(kv_count), 32'(vecs[i].e_count));
      check($sformatf("vec%0d_ovf", i),   32'(ovf),      32'(vecs[i].e_ovf));
      if (vecs[i].e_valid)
        check($sformatf("vec%0d_data", i), 32'(kv_data), 32'(vecs[i].e_data));
    end

    // Overflow: codes 0..8 with no reads, code 8 is dropped.
    for (int i = 0; i < 9; i++) cycle(1, i, 0, 0);
    #1;
    check("ovf_full_count", 32'(kv_count), 8);
    check("ovf_set", 32'(ovf), 1);
    cycle(0, 0, 0, 1); #1;
    check("ovf_cleared", 32'(ovf), 0);
    cycle(1, 9, 0, 1); #1;
    check("ovf_set_wins", 32'(ovf), 1);
    check("ovf_head", 32'(kv_data), 0);
    for (int i = 1; i < 8; i++) begin
      cycle(0, 0, 1, 0); #1;
      check("ovf_order", 32'(kv_data), i);
    end
    cycle(0, 0, 1, 0); #1;
    check("ovf_drained", 32'(kv_valid), 0);
    cycle(0, 0, 0, 1);

    // Full with simultaneous read and write.
    for (int i = 0; i < 8; i++) cycle(1, 'h10 + i, 0, 0);
    cycle(1, 'h1F, 1, 0); #1;
    check("frw_count", 32'(kv_count), 8);
    check("frw_ovf", 32'(ovf), 0);
    drain(20);
    check("frw_last", last_pop, 'h1F);

    // Reset between edges with 5 entries stored.
    for (int i = 0; i < 5; i++) cycle(1, 'h08 + i, 0, 0);
    #1;
    check("pre_rst_count", 32'(kv_count), 5);
    nkpls = 1'b0; kv_ready = 1'b0; ovf_clr = 1'b0;
    #20; rst = 1'b1; #1;
    check("mid_rst_valid", 32'(kv_valid), 0);
    check("mid_rst_count", 32'(kv_count), 0);
    check("mid_rst_data",  32'(kv_data),  0);
    exp_q.delete(); m_ovf = 0;
`ifdef KEY_EVT_FIFO_TS_EN
    m_ts = 0;
`endif
    // A pulse while reset is still asserted must not be stored.
    @(negedge clk); nkpls = 1'b1; nkv = 5'h1E;
    @(negedge clk); rst = 1'b0; nkpls = 1'b0;
    cycle(1, 3, 0, 0); #1;
    check("post_rst_count", 32'(kv_count), 1);
    check("post_rst_data",  32'(kv_data),  3);
    drain(4);

`ifdef KEY_EVT_FIFO_TS_EN
    pls_nxt = 1'b1;
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    pls_nxt = 1'b0;
    cycle(1, 7, 0, 0); #1;
    check("ts_first", 32'(kv_ts), 3);
    drain(4);
    pls_nxt = 1'b1;
    for (int i = 0; i < 256; i++) cycle(0, 0, 0, 0);
    pls_nxt = 1'b0;
    cycle(1, 7, 0, 0); #1;
    check("ts_wrap", 32'(kv_ts), 3);
    drain(4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
